// File: rtl/aemb2_pkg.sv
// Shared definitions for the AEMB2 execution units: data width, default
// multiplier latency and small helpers used by the schedulers.
package aemb2_pkg;

  localparam int unsigned AEMB2_DW      = 32;
  localparam int unsigned AEMB2_MUL_LAT = 2;
  // Requester ids are carried at full width so up to 8 requesters fit.
  localparam int unsigned AEMB2_IDW     = 3;
  localparam int unsigned AEMB2_MAXREQ  = 8;

  typedef logic [AEMB2_IDW-1:0] req_id_t;

  // One entry of the tag pipeline that tracks a product through the multiplier.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } mul_tag_t;

  // Binary index of a one-hot vector; returns 0 for an all-zero input.
  function automatic req_id_t onehot2bin(input logic [AEMB2_MAXREQ-1:0] oh);
    req_id_t b;
    b = '0;
    for (int i = 0; i < int'(AEMB2_MAXREQ); i++) begin
      if (oh[i]) begin
        b = b | req_id_t'(i);
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/aemb2_mul_sched_if.sv
// Requester and multiplier side signals of the multiplier scheduler.
// The slave modport is the scheduler; the master modport is its environment
// (requesters plus the multiplier result).
interface aemb2_mul_sched_if #(
  parameter int unsigned NREQ = 4
);
  import aemb2_pkg::*;

  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          kill;
  logic [AEMB2_DW*NREQ-1:0] opa;
  logic [AEMB2_DW*NREQ-1:0] opb;
  logic [NREQ-1:0]          ack;
  logic [NREQ-1:0]          rsp_vld;
  logic [AEMB2_DW-1:0]      rsp_dat;
  logic [AEMB2_DW-1:0]      mul_opa;
  logic [AEMB2_DW-1:0]      mul_opb;
  logic [AEMB2_DW-1:0]      mul_res;

  modport master (
    output req, kill, opa, opb, mul_res,
    input  ack, rsp_vld, rsp_dat, mul_opa, mul_opb
  );

  modport slave (
    input  req, kill, opa, opb, mul_res,
    output ack, rsp_vld, rsp_dat, mul_opa, mul_opb
  );

endinterface

// File: rtl/aemb2_rr_arb.sv
// Combinational round-robin arbiter. The requester at ptr has highest
// priority; the next pointer is one past the winner, or ptr when idle.
module aemb2_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   ptr_nxt
);

  // Scan from ptr upward (wrapping) and take the first eligible requester.
  always_comb begin
    logic found;
    int unsigned idx;
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (en && !found && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = (idx + 1 == NREQ) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/aemb2_mul_sched.sv
// Round-robin scheduler sharing one pipelined 32x32 multiplier between NREQ
// requesters. A tag pipeline matched to the multiplier depth routes each
// product back to its originator; kill drops a requester's in-flight work.
module aemb2_mul_sched
  import aemb2_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = AEMB2_MUL_LAT
) (
  input  logic               gclk,
  input  logic               grst,
  input  logic               dena,
  aemb2_mul_sched_if.slave   bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]           ptr_q, ptr_nxt;
  logic [NREQ-1:0]         outst_q, outst_d;
  logic [NREQ-1:0]         elig, gnt, rsp_vld;
  logic [AEMB2_MAXREQ-1:0] kill_w, rsp_w;
  logic                    run, grant_any;
  req_id_t                 gid;
  mul_tag_t                tag_q [MUL_LAT];
  mul_tag_t                tag_d [MUL_LAT];
  mul_tag_t                tail;
  logic [AEMB2_DW-1:0]     mux_a, mux_b;

  // Widened kill so tag ids can index it without range concerns.
  assign kill_w = AEMB2_MAXREQ'(bus.kill);
  assign tail   = tag_q[MUL_LAT-1];

  // Holding grants in reset keeps ack and the operand bus quiet.
  assign run = dena & grst;

  // Response strobe for the tail tag; suppressed while frozen or killed.
  always_comb begin
    rsp_w = '0;
    if (tail.vld && dena && !kill_w[tail.id]) begin
      rsp_w[tail.id] = 1'b1;
    end
  end
  assign rsp_vld = rsp_w[NREQ-1:0];

  // A requester whose result returns this cycle may issue again immediately.
  assign elig = bus.req & ~bus.kill & (~outst_q | rsp_vld);

  aemb2_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .elig    (elig),
    .ptr     (ptr_q),
    .en      (run),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  assign grant_any = |gnt;
  assign gid       = onehot2bin(AEMB2_MAXREQ'(gnt));

  // Operand steering: AND-OR mux over the one-hot grant, zero when idle.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mux_a = mux_a | bus.opa[AEMB2_DW*i +: AEMB2_DW];
        mux_b = mux_b | bus.opb[AEMB2_DW*i +: AEMB2_DW];
      end
    end
  end

  assign bus.ack     = gnt;
  assign bus.rsp_vld = rsp_vld;
  assign bus.rsp_dat = bus.mul_res;
  assign bus.mul_opa = mux_a;
  assign bus.mul_opb = mux_b;

  // Outstanding bits: set on grant, cleared on delivery or kill.
  always_comb begin
    outst_d = (outst_q & ~rsp_vld) | gnt;
    outst_d = outst_d & ~bus.kill;
  end

  // Tag pipeline next state: shift when enabled, else hold; kill applies always.
  always_comb begin
    mul_tag_t src;
    src = '0;
    for (int unsigned k = 0; k < MUL_LAT; k++) begin
      if (!dena) begin
        src = tag_q[k];
      end else if (k == 0) begin
        src.vld = grant_any;
        src.id  = gid;
      end else begin
        src = tag_q[k-1];
      end
      tag_d[k].vld = src.vld & ~kill_w[src.id];
      tag_d[k].id  = src.id;
    end
  end

  // State registers; dena gating is folded into the next-state logic.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      ptr_q   <= '0;
      outst_q <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q   <= ptr_nxt;
      outst_q <= outst_d;
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

endmodule

// File: doc/aemb2_mul_sched.md
# aemb2_mul_sched

Round-robin scheduler that shares the single two-stage pipelined 32x32 multiplier between up to NREQ requesters, for example per-thread execute ports or a coprocessor port. It grants one request per enabled cycle and steers the granted operands onto the multiplier inputs. A tag pipeline matched to the multiplier latency routes each product back to its originator as a one-cycle response strobe. Per-requester kill lets a squashed instruction drop its in-flight product.

## Interface
- NREQ, 4: number of requesters, 2..8.
- MUL_LAT, 2: multiplier latency in dena-qualified edges; must equal the multiplier's pipeline depth.
- gclk  in  1: system clock; all state on its rising edge.
- grst  in  1: reset, asynchronous, active-low.
- dena  in  1: global pipeline enable, shared with the multiplier; low freezes all state.
- req  in  NREQ: request, level; operands must be valid while high.
- opa  in  32*NREQ: operand A, requester i at [32i+31:32i].
- opb  in  32*NREQ: operand B, same packing.
- kill  in  NREQ: squash all in-flight and pending work of requester i.
- ack  out  NREQ: one-hot grant; operands are captured by the multiplier at this cycle's edge.
- rsp_vld  out  NREQ: one-hot response strobe.
- rsp_dat  out  32: product, low 32 bits; valid when any rsp_vld bit is set.
- mul_opa  out  32: operand A to the multiplier.
- mul_opb  out  32: operand B to the multiplier.
- mul_res  in  32: multiplier output.

## Operation
- Eligibility: requester i is eligible iff req[i] & ~kill[i] & (~outstanding[i] | rsp_vld[i]). This allows back-to-back issue on the cycle its previous result returns.
- Arbitration:
  - Combinational round robin over eligible requesters, highest priority at pointer ptr.
  - No grant while dena = 0.
  - On a grant to i at an enabled edge, ptr <= (i+1) mod NREQ; otherwise ptr holds.
- Issue:
  - mul_opa/mul_opb = operands of the granted requester; 0 when there is no grant.
  - On the enabled edge, tag stage 0 <= {valid=1, id=i} and outstanding[i] <= 1.
  - With no grant, stage 0 valid <= 0.
- Tag pipeline: MUL_LAT stages, shifting only when dena = 1, in lock-step with the multiplier.
- Response:
  - rsp_vld[id] = tail.valid & dena & ~kill[id]; rsp_dat = mul_res.
  - At the delivering edge, outstanding[id] <= 0 unless re-granted that same cycle.
- Kill[i]:
  - Clears valid of every tag stage whose id = i.
  - Clears outstanding[i] and suppresses any rsp_vld[i] that cycle.
  - Takes effect even when dena = 0.
  - The multiplier still computes the product; it is simply discarded.
- Constraint: at most one request per requester is in flight.
- Reset: ptr = 0, all tag stages invalid, outstanding = 0. ack, rsp_vld, mul_opa and mul_opb are 0 while reset is asserted and afterward until a grant occurs. rsp_dat is don't-care.

## Timing
- Grant is combinational: ack in cycle t, same cycle as eligible req. The requester may drop req or present a new op in t+1.
- Response in cycle t+MUL_LAT (enabled cycles), i.e. 2 enabled cycles after the grant with the default latency.
- Each dena-low cycle adds one cycle of latency. rsp_vld is deasserted while dena = 0 and reasserts when dena rises, so no duplicate delivery occurs.
- Throughput: one issue per enabled cycle across all requesters, one per MUL_LAT cycles per requester.
- Reset mid-operation discards all in-flight results. No rsp_vld is produced for them after grst releases.
- Simultaneous kill[i] and req[i]: no grant to i; ptr unaffected by i.

## Structure
- Shared package aemb2_pkg:
  - AEMB2_DW = 32.
  - AEMB2_MUL_LAT = 2, the default for MUL_LAT.
  - Function onehot2bin.
- Sub-module aemb2_rr_arb: parameterised NREQ round-robin arbiter.
  - Inputs: eligible vector, pointer, enable.
  - Outputs: one-hot grant and next pointer.
  - Reusable for other shared execution units.
- Top level contains the operand mux, tag pipeline, outstanding bits and kill logic.

## Test plan
- Single op: req[1] with opa=7, opb=6 at t -> ack=0010 at t; rsp_vld=0010 and rsp_dat=42 at t+2; no other strobes.
- Contention: req=1111 held from t, each requester dropping req after its ack -> grants 0,1,2,3 at t..t+3; responses in the same order at t+2..t+5 with matching products.
- Back-to-back: req[0] held continuously, operands advanced after each ack -> ack[0] every 2 cycles; each rsp_vld[0] coincides with the next ack[0].
- Stall: grant at t, then dena=0 for 3 cycles at t+1 -> rsp_vld[2] at t+5 exactly once; ack stays 0 during the stall.
- Kill: grant to 3 at t, kill[3] at t+1 -> no rsp_vld[3]; outstanding[3] clear, so a req[3] at t+2 is granted; an unrelated requester's result is still delivered.
- Reset mid-flight: two ops in flight, grst pulsed low -> all outputs 0 while reset is asserted; no responses after release; the first grant after reset goes to requester 0 when req=1111.
